// File: rtl/wb_dmi_bridge.sv
// Wishbone-slave register bridge driving the debug module's DMI request/response port.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   wbs_cyc/stb/we/adr/dat_i/sel     Wishbone pipelined slave inputs (sel ignored)
//   wbs_dat_o, wbs_ack               registered read data / acknowledge
//   wbs_stall, wbs_err               tied low
//   dmi_rst_n                        debug-module reset pulse, active low
//   dmi_req_valid/ready, dmi_req_*   DMI request channel {addr, op, data}
//   dmi_resp_valid/ready, dmi_resp_* DMI response channel {data, resp}
module wb_dmi_bridge #(
    parameter int unsigned BusWidth = 32,
    parameter int unsigned DmiAbits = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wbs_cyc,
    input  logic                  wbs_stb,
    input  logic                  wbs_we,
    input  logic [BusWidth-1:0]   wbs_adr,
    input  logic [BusWidth-1:0]   wbs_dat_i,
    input  logic [BusWidth/8-1:0] wbs_sel,
    output logic [BusWidth-1:0]   wbs_dat_o,
    output logic                  wbs_ack,
    output logic                  wbs_stall,
    output logic                  wbs_err,
    output logic                  dmi_rst_n,
    output logic                  dmi_req_valid,
    input  logic                  dmi_req_ready,
    output logic [DmiAbits-1:0]   dmi_req_addr,
    output logic [1:0]            dmi_req_op,
    output logic [31:0]           dmi_req_data,
    input  logic                  dmi_resp_valid,
    output logic                  dmi_resp_ready,
    input  logic [31:0]           dmi_resp_data,
    input  logic [1:0]            dmi_resp_resp
);

    localparam logic [1:0] RegData   = 2'd0;
    localparam logic [1:0] RegAddr   = 2'd1;
    localparam logic [1:0] RegCmd    = 2'd2;
    localparam logic [1:0] RegStatus = 2'd3;
    localparam logic [1:0] OpRead    = 2'd1;
    localparam logic [1:0] OpWrite   = 2'd2;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    state_e                state_q, state_d;
    logic [31:0]           wdata_q, rdata_q;
    logic [DmiAbits-1:0]   addr_q;
    logic                  err_q, drop_q;
    logic [1:0]            last_resp_q;
    logic [1:0]            rst_cnt_q;

    logic                  wb_req_c, wb_wr_c, start_c, rst_cmd_c, status_wr_c, pulse_active_c;
    logic [1:0]            reg_sel_c;
    logic                  load_req, capture, drop_set;
    logic [31:0]           rd_mux_c;
    logic                  unused_bits;

    assign wbs_stall   = 1'b0;
    assign wbs_err     = 1'b0;
    assign unused_bits = ^{wbs_adr[BusWidth-1:4], wbs_adr[1:0], wbs_sel};

    // Bus decode
    assign wb_req_c       = wbs_cyc & wbs_stb;
    assign wb_wr_c        = wb_req_c & wbs_we;
    assign reg_sel_c      = wbs_adr[3:2];
    assign start_c        = wb_wr_c && (reg_sel_c == RegCmd) && (wbs_dat_i[0] || wbs_dat_i[1]);
    assign rst_cmd_c      = wb_wr_c && (reg_sel_c == RegCmd) && wbs_dat_i[2];
    assign status_wr_c    = wb_wr_c && (reg_sel_c == RegStatus);
    assign pulse_active_c = (rst_cnt_q != 2'd0);

    // Read mux, sampled on the strobe cycle
    always_comb begin
        rd_mux_c = 32'd0;
        case (reg_sel_c)
            RegData:   rd_mux_c = rdata_q;
            RegAddr:   rd_mux_c = 32'(addr_q);
            RegStatus: rd_mux_c = {26'd0, last_resp_q, 1'b0, drop_q, err_q, state_q != IDLE};
            default:   rd_mux_c = 32'd0;
        endcase
    end

    // Next-state logic; a DMI reset command or an active pulse abandons any transaction
    always_comb begin
        state_d  = state_q;
        load_req = 1'b0;
        capture  = 1'b0;
        drop_set = 1'b0;
        if (rst_cmd_c || pulse_active_c) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_c) begin
                        state_d  = REQ;
                        load_req = 1'b1;
                    end
                end
                REQ: begin
                    drop_set = start_c;
                    if (dmi_req_ready) state_d = RESP;
                end
                RESP: begin
                    drop_set = start_c;
                    if (dmi_resp_valid) begin
                        capture = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Registers, outputs and handshake flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbs_ack        <= 1'b0;
            wbs_dat_o      <= '0;
            dmi_req_valid  <= 1'b0;
            dmi_resp_ready <= 1'b0;
            dmi_req_addr   <= '0;
            dmi_req_op     <= '0;
            dmi_req_data   <= '0;
            dmi_rst_n      <= 1'b1;
            rst_cnt_q      <= 2'd0;
            wdata_q        <= '0;
            rdata_q        <= '0;
            addr_q         <= '0;
            err_q          <= 1'b0;
            drop_q         <= 1'b0;
            last_resp_q    <= 2'd0;
        end else begin
            wbs_ack        <= wb_req_c;
            if (wb_req_c) wbs_dat_o <= BusWidth'(rd_mux_c);
            dmi_req_valid  <= (state_d == REQ);
            dmi_resp_ready <= (state_d == RESP);

            if (load_req) begin
                dmi_req_op   <= wbs_dat_i[0] ? OpRead : OpWrite;
                dmi_req_addr <= addr_q;
                dmi_req_data <= wdata_q;
            end

            if (wb_wr_c && reg_sel_c == RegData) wdata_q <= 32'(wbs_dat_i);
            if (wb_wr_c && reg_sel_c == RegAddr) addr_q  <= wbs_dat_i[DmiAbits-1:0];

            // Sticky flags: set has priority over a same-cycle W1C
            err_q  <= (err_q  & ~(status_wr_c & wbs_dat_i[1])) | (capture && dmi_resp_resp != 2'd0);
            drop_q <= (drop_q & ~(status_wr_c & wbs_dat_i[2])) | drop_set;

            if (capture) begin
                rdata_q     <= dmi_resp_data;
                last_resp_q <= dmi_resp_resp;
            end

            // Two-cycle low pulse starting the cycle after the command write
            if (rst_cmd_c)           rst_cnt_q <= 2'd2;
            else if (pulse_active_c) rst_cnt_q <= rst_cnt_q - 2'd1;
            dmi_rst_n <= !(rst_cmd_c || rst_cnt_q == 2'd2);
        end
    end

endmodule

// File: tb/tb_wb_dmi_bridge.sv
module tb_wb_dmi_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [31:0] adr, dat_i;
    logic [3:0]  sel;
    logic [31:0] dat_o;
    logic        ack, stall, err;
    logic        dmi_rst_n, req_valid, req_ready, resp_valid, resp_ready;
    logic [6:0]  req_addr;
    logic [1:0]  req_op, resp_resp;
    logic [31:0] req_data, resp_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_dmi_bridge #(.BusWidth(32), .DmiAbits(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .wbs_cyc(cyc), .wbs_stb(stb), .wbs_we(we), .wbs_adr(adr), .wbs_dat_i(dat_i),
        .wbs_sel(sel), .wbs_dat_o(dat_o), .wbs_ack(ack), .wbs_stall(stall), .wbs_err(err),
        .dmi_rst_n(dmi_rst_n), .dmi_req_valid(req_valid), .dmi_req_ready(req_ready),
        .dmi_req_addr(req_addr), .dmi_req_op(req_op), .dmi_req_data(req_data),
        .dmi_resp_valid(resp_valid), .dmi_resp_ready(resp_ready),
        .dmi_resp_data(resp_data), .dmi_resp_resp(resp_resp)
    );

    // Transaction-level reference: a request is "pending" from the start command
    // until its response, and "accepted" once the DM has taken it.
    bit          m_pending, m_accepted, m_err, m_drop, m_ack;
    logic [31:0] m_wdata, m_rdata, m_dat, m_req_data;
    logic [6:0]  m_addr, m_req_addr;
    logic [1:0]  m_resp, m_req_op;
    int          m_rst_left;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return m_rdata;
            2'd1:    return {25'd0, m_addr};
            2'd3:    return {26'd0, m_resp, 1'b0, m_drop, m_err, m_pending};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_pending = 0; m_accepted = 0; m_err = 0; m_drop = 0; m_ack = 0;
        m_wdata = 0; m_rdata = 0; m_dat = 0; m_req_data = 0;
        m_addr = 0; m_req_addr = 0; m_resp = 0; m_req_op = 0; m_rst_left = 0;
    endtask

    // Advance the model by one clock edge using the inputs held across that edge
    task automatic model_step();
        bit strobe, write, busy, pulse_now, rcmd, start, resp_done, accepting;
        logic [1:0] a;
        if (!rst_n) begin
            model_reset();
            return;
        end
        strobe    = cyc & stb;
        write     = strobe & we;
        a         = adr[3:2];
        busy      = m_pending;
        pulse_now = (m_rst_left > 0);
        rcmd      = write && a == 2'd2 && dat_i[2];
        start     = write && a == 2'd2 && (dat_i[0] || dat_i[1]);
        resp_done = m_pending && m_accepted && resp_valid;
        accepting = m_pending && !m_accepted && req_ready;

        m_ack = strobe;
        if (strobe) m_dat = m_read(a);

        if (write && a == 2'd0) m_wdata = dat_i;
        if (write && a == 2'd1) m_addr  = dat_i[6:0];
        if (write && a == 2'd3) begin
            if (dat_i[1]) m_err  = 0;
            if (dat_i[2]) m_drop = 0;
        end

        if (rcmd) begin
            m_pending = 0;
            m_accepted = 0;
        end else if (!pulse_now) begin
            if (resp_done) begin
                m_rdata = resp_data;
                m_resp  = resp_resp;
                if (resp_resp != 2'd0) m_err = 1;
                m_pending = 0;
                m_accepted = 0;
            end else if (accepting) begin
                m_accepted = 1;
            end
            if (start) begin
                if (busy) m_drop = 1;
                else begin
                    m_pending  = 1;
                    m_accepted = 0;
                    m_req_op   = dat_i[0] ? 2'd1 : 2'd2;
                    m_req_addr = m_addr;
                    m_req_data = m_wdata;
                end
            end
        end

        if (m_rst_left > 0) m_rst_left--;
        if (rcmd) m_rst_left = 2;
    endtask

    task automatic compare();
        chk("ack",        32'(ack),        32'(m_ack));
        chk("dat_o",      dat_o,           m_dat);
        chk("stall",      32'(stall),      32'd0);
        chk("err",        32'(err),        32'd0);
        chk("req_valid",  32'(req_valid),  32'(m_pending && !m_accepted));
        chk("resp_ready", 32'(resp_ready), 32'(m_pending && m_accepted));
        chk("req_addr",   32'(req_addr),   32'(m_req_addr));
        chk("req_op",     32'(req_op),     32'(m_req_op));
        chk("req_data",   req_data,        m_req_data);
        chk("dmi_rst_n",  32'(dmi_rst_n),  32'(m_rst_left == 0));
    endtask

    task automatic cycle();
        @(negedge clk);
        model_step();
        compare();
    endtask

    task automatic bus_idle();
        cyc = 0; stb = 0; we = 0; adr = 0; dat_i = 0;
    endtask

    task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
        cyc = 1; stb = 1; we = 1; dat_i = d;
        adr = {$urandom_range(0, 32'h0FFF_FFFF), a[3:2], 2'($urandom_range(0, 3))};
        cycle();
        bus_idle();
    endtask

    task automatic wb_read(input logic [3:0] a, output logic [31:0] d);
        cyc = 1; stb = 1; we = 0; dat_i = $urandom;
        adr = {28'd0, a[3:2], 2'd0};
        cycle();
        d = dat_o;
        bus_idle();
    endtask

    logic [31:0] rd;

    initial begin
        sel = 4'hF;
        bus_idle();
        req_ready = 0; resp_valid = 0; resp_data = 0; resp_resp = 0;
        model_reset();
        rst_n = 0;
        cycle(); cycle();
        chk("rst_dmi_rst_n", 32'(dmi_rst_n), 32'd1);
        chk("rst_valid",     32'(req_valid), 32'd0);
        rst_n = 1;
        cycle();

        // T1: read of address 0x11, quick response
        req_ready = 1;
        wb_write(4'h4, 32'h11);
        wb_write(4'h8, 32'h1);
        chk("t1_valid", 32'(req_valid), 32'd1);
        chk("t1_addr",  32'(req_addr),  32'h11);
        chk("t1_op",    32'(req_op),    32'd1);
        cycle();
        req_ready = 0; resp_valid = 1; resp_data = 32'h2; resp_resp = 0;
        cycle();
        resp_valid = 0;
        wb_read(4'h0, rd); chk("t1_data",   rd, 32'h2);
        wb_read(4'hC, rd); chk("t1_status", rd, 32'h0);

        // T2: write held off by ready for 5 cycles
        wb_write(4'h0, 32'h8000_0001);
        wb_write(4'h4, 32'h10);
        wb_write(4'h8, 32'h2);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t2_valid", 32'(req_valid), 32'd1);
            chk("t2_op",    32'(req_op),    32'd2);
            chk("t2_data",  req_data,       32'h8000_0001);
        end
        req_ready = 1;
        cycle();
        req_ready = 0;
        chk("t2_resp_ready", 32'(resp_ready), 32'd1);

        // T3: start while busy is dropped, drop clears by W1C
        wb_write(4'h8, 32'h1);
        chk("t3_no_req", 32'(req_valid), 32'd0);
        wb_read(4'hC, rd); chk("t3_status", rd, 32'h5);
        wb_write(4'hC, 32'h4);
        resp_valid = 1; resp_data = 32'hDEAD; resp_resp = 0;
        cycle();
        resp_valid = 0;
        wb_read(4'hC, rd); chk("t3_cleared", rd, 32'h0);

        // T4: error response is sticky across a later OK transaction
        req_ready = 1;
        wb_write(4'h8, 32'h1);
        cycle();
        req_ready = 0; resp_valid = 1; resp_data = 32'h1234; resp_resp = 2;
        cycle();
        resp_valid = 0;
        wb_write(4'h8, 32'h1);
        wb_read(4'hC, rd); chk("t4_status_busy", rd, 32'h23);
        req_ready = 1;
        cycle();
        req_ready = 0; resp_valid = 1; resp_resp = 0;
        cycle();
        resp_valid = 0;
        wb_read(4'hC, rd); chk("t4_err_sticky", rd, 32'h2);
        wb_write(4'hC, 32'h2);
        wb_read(4'hC, rd); chk("t4_err_clear", rd, 32'h0);

        // T5: DMI reset pulse while waiting for a response
        req_ready = 1;
        wb_write(4'h8, 32'h2);
        cycle();
        req_ready = 0;
        chk("t5_in_resp", 32'(resp_ready), 32'd1);
        wb_write(4'h8, 32'h4);
        chk("t5_pulse0", 32'(dmi_rst_n), 32'd0);
        chk("t5_abort",  32'(resp_ready), 32'd0);
        cycle();
        chk("t5_pulse1", 32'(dmi_rst_n), 32'd0);
        cycle();
        chk("t5_pulse_end", 32'(dmi_rst_n), 32'd1);
        wb_read(4'hC, rd); chk("t5_status", rd, 32'h0);

        // T6: asynchronous reset while a request is outstanding
        wb_write(4'h8, 32'h1);
        #2 rst_n = 0;
        #1;
        chk("t6_valid", 32'(req_valid), 32'd0);
        chk("t6_ack",   32'(ack),       32'd0);
        chk("t6_op",    32'(req_op),    32'd0);
        chk("t6_rstn",  32'(dmi_rst_n), 32'd1);
        cycle();
        rst_n = 1;
        cycle();
        req_ready = 1;
        wb_write(4'h8, 32'h1);
        chk("t6_restart", 32'(req_valid), 32'd1);
        cycle();
        req_ready = 0; resp_valid = 1; resp_data = 32'h7; resp_resp = 0;
        cycle();
        resp_valid = 0;
        wb_read(4'h0, rd); chk("t6_data", rd, 32'h7);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 2) == 0) begin
                cyc = 1; stb = 1; we = 1'($urandom_range(0, 1));
                adr = $urandom;
                if (adr[3:2] == 2'd2)
                    dat_i = {29'($urandom), ($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3))};
                else
                    dat_i = $urandom;
            end else begin
                cyc = 1'($urandom_range(0, 1)); stb = 0; we = 1'($urandom_range(0, 1));
                adr = $urandom; dat_i = $urandom;
            end
            req_ready  = 1'($urandom_range(0, 1));
            resp_valid = ($urandom_range(0, 2) == 0);
            resp_data  = $urandom;
            resp_resp  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            cycle();
        end
        rst_n = 1;
        bus_idle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
